// File: rtl/vga_pkg.sv
// Shared VGA sprite types and geometry defaults.
// Used by the rect controller, draw_rect and the timing chain.
package vga_pkg;

   localparam int DEF_RECT_H   = 64;
   localparam int DEF_SCREEN_H = 600;

   typedef enum logic [1:0] {
      FOLLOW,
      FALL,
      RISE,
      REST
   } rect_ctl_state_t;

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector with synchronous reset.
// pulse is combinational: high in the first cycle d is seen high.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Sprite position controller: follows the mouse, or falls and
// bounces under frame-stepped gravity after a left click.
module draw_rect_ctl
   import vga_pkg::*;
#(
   parameter int RECT_H   = DEF_RECT_H,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int GRAVITY  = 1,
   parameter int VMAX     = 64,
   parameter int VMIN     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        moving
);

   localparam logic [11:0] BOTTOM = 12'(SCREEN_H - RECT_H);
   localparam logic [11:0] G12    = 12'(GRAVITY);
   localparam logic [11:0] VMAX12 = 12'(VMAX);
   localparam logic [11:0] VMIN12 = 12'(VMIN);

   rect_ctl_state_t state, state_nxt;
   logic [11:0] vel, vel_nxt;
   logic [11:0] x_nxt, y_nxt;
   logic        click, tick;

   logic [12:0] v_add, y_sum, y_dif;
   logic [11:0] v_fall, v_bnc, v_dec;

   edge_det u_click (
      .clk   (clk),
      .rst   (rst),
      .d     (mouse_left),
      .pulse (click)
   );

   edge_det u_tick (
      .clk   (clk),
      .rst   (rst),
      .d     (vblnk),
      .pulse (tick)
   );

   always_comb begin
      state_nxt = state;
      vel_nxt   = vel;
      x_nxt     = xpos;
      y_nxt     = ypos;

      v_add  = {1'b0, vel} + {1'b0, G12};
      v_fall = (v_add > {1'b0, VMAX12}) ? VMAX12 : v_add[11:0];
      y_sum  = {1'b0, ypos} + {1'b0, v_fall};
      v_bnc  = v_fall - (v_fall >> 2);
      v_dec  = vel - G12;
      y_dif  = {1'b0, ypos} - {1'b0, v_dec};

      // click takes priority over tick in every state
      unique case (state)
         FOLLOW: begin
            x_nxt = mouse_xpos;
            y_nxt = (mouse_ypos > BOTTOM) ? BOTTOM : mouse_ypos;
            if (click) begin
               state_nxt = FALL;
               vel_nxt   = '0;
            end
         end
         FALL: begin
            if (click) begin
               state_nxt = FOLLOW;
               vel_nxt   = '0;
            end else if (tick) begin
               if (y_sum >= {1'b0, BOTTOM}) begin
                  y_nxt = BOTTOM;
                  if (v_bnc < VMIN12) begin
                     state_nxt = REST;
                     vel_nxt   = '0;
                  end else begin
                     state_nxt = RISE;
                     vel_nxt   = v_bnc;
                  end
               end else begin
                  y_nxt   = y_sum[11:0];
                  vel_nxt = v_fall;
               end
            end
         end
         RISE: begin
            if (click) begin
               state_nxt = FOLLOW;
               vel_nxt   = '0;
            end else if (tick) begin
               if (vel <= G12) begin
                  state_nxt = FALL;
                  vel_nxt   = '0;
               end else if (y_dif[12]) begin
                  state_nxt = FALL;
                  vel_nxt   = '0;
                  y_nxt     = '0;
               end else begin
                  vel_nxt = v_dec;
                  y_nxt   = y_dif[11:0];
               end
            end
         end
         REST: begin
            y_nxt = BOTTOM;
            if (click) state_nxt = FOLLOW;
         end
         default: state_nxt = FOLLOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FOLLOW;
         vel    <= '0;
         xpos   <= '0;
         ypos   <= '0;
         moving <= 1'b0;
      end else begin
         state  <= state_nxt;
         vel    <= vel_nxt;
         xpos   <= x_nxt;
         ypos   <= y_nxt;
         moving <= (state == FALL) || (state == RISE);
      end
   end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: follow, fall/bounce,
// ripple to rest, click/tick collision, held button, reset.
module tb_draw_rect_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic        vblnk;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        moving;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   draw_rect_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .mouse_left (mouse_left),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .xpos       (xpos),
      .ypos       (ypos),
      .moving     (moving)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      vblnk = 1'b1;
      step();
      step();
      vblnk = 1'b0;
      step();
      step();
   endtask

   task automatic press();
      mouse_left = 1'b1;
      step();
      mouse_left = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_chk++;
      if ({xpos, ypos, moving} !== 25'd0)
         $display("FAIL reset_init x=%0d y=%0d mv=%0b want 0 0 0",
                  xpos, ypos, moving);
      else n_pass++;
      rst = 1'b0;
      mouse_xpos = 12'd50;
      mouse_ypos = 12'd100;
      step();
      press();
      frame();
      n_chk++;
      if (ypos !== 12'd101 || moving !== 1'b1)
         $display("FAIL pre_reset_fall y=%0d mv=%0b want 101 1",
                  ypos, moving);
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_chk++;
      if ({xpos, ypos, moving} !== 25'd0)
         $display("FAIL reset_midfall x=%0d y=%0d mv=%0b want 0 0 0",
                  xpos, ypos, moving);
      else n_pass++;
      step();
      n_chk++;
      if (xpos !== 12'd50 || ypos !== 12'd100)
         $display("FAIL reset_follow x=%0d y=%0d want 50 100",
                  xpos, ypos);
      else n_pass++;
   endtask

   task automatic test_follow();
      mouse_ypos = 12'd580;
      step();
      n_chk++;
      if (ypos !== 12'd536)
         $display("FAIL follow_clamp y=%0d want 536", ypos);
      else n_pass++;
      mouse_xpos = 12'd300;
      n_chk++;
      if (xpos !== 12'd50)
         $display("FAIL follow_early x=%0d want 50", xpos);
      else n_pass++;
      step();
      n_chk++;
      if (xpos !== 12'd300)
         $display("FAIL follow_x x=%0d want 300", xpos);
      else n_pass++;
   endtask

   task automatic test_fall_bounce();
      logic [11:0] exp_y [8];
      exp_y = '{12'd501, 12'd503, 12'd506, 12'd510,
                12'd515, 12'd521, 12'd528, 12'd536};
      mouse_ypos = 12'd500;
      step();
      press();
      n_chk++;
      if (moving !== 1'b1 || ypos !== 12'd500)
         $display("FAIL click_fall mv=%0b y=%0d want 1 500",
                  moving, ypos);
      else n_pass++;
      mouse_xpos = 12'd777;
      for (int i = 0; i < 8; i++) begin
         frame();
         n_chk++;
         if (ypos !== exp_y[i] || xpos !== 12'd300)
            $display("FAIL fall_tick%0d y=%0d x=%0d want %0d 300",
                     i + 1, ypos, xpos, exp_y[i]);
         else n_pass++;
      end
      n_chk++;
      if (moving !== 1'b1)
         $display("FAIL bounce_moving mv=%0b want 1", moving);
      else n_pass++;
      frame();
      n_chk++;
      if (ypos !== 12'd531 || xpos !== 12'd300)
         $display("FAIL rise_tick9 y=%0d x=%0d want 531 300",
                  ypos, xpos);
      else n_pass++;
   endtask

   task automatic test_click_tick();
      mouse_xpos = 12'd20;
      mouse_ypos = 12'd100;
      mouse_left = 1'b1;
      vblnk = 1'b1;
      step();
      n_chk++;
      if (ypos !== 12'd531 || xpos !== 12'd300)
         $display("FAIL click_tick_hold y=%0d x=%0d want 531 300",
                  ypos, xpos);
      else n_pass++;
      step();
      n_chk++;
      if (ypos !== 12'd100 || xpos !== 12'd20 || moving !== 1'b0)
         $display("FAIL click_tick_follow y=%0d x=%0d mv=%0b want 100 20 0",
                  ypos, xpos, moving);
      else n_pass++;
      mouse_left = 1'b0;
      vblnk = 1'b0;
      step();
      step();
   endtask

   task automatic test_ripple();
      logic [11:0] exp_y [5];
      exp_y = '{12'd535, 12'd536, 12'd535, 12'd535, 12'd536};
      mouse_ypos = 12'd534;
      step();
      press();
      for (int i = 0; i < 5; i++) begin
         frame();
         n_chk++;
         if (ypos !== exp_y[i])
            $display("FAIL ripple_tick%0d y=%0d want %0d",
                     i + 1, ypos, exp_y[i]);
         else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         frame();
         n_chk++;
         if (ypos < 12'd535 || ypos > 12'd536)
            $display("FAIL ripple_bound y=%0d want 535..536", ypos);
         else n_pass++;
      end
      n_chk++;
      if (moving !== 1'b0 || ypos !== 12'd536)
         $display("FAIL rest_state mv=%0b y=%0d want 0 536",
                  moving, ypos);
      else n_pass++;
   endtask

   task automatic test_hold();
      mouse_ypos = 12'd200;
      press();
      n_chk++;
      if (ypos !== 12'd200 || moving !== 1'b0)
         $display("FAIL rest_to_follow y=%0d mv=%0b want 200 0",
                  ypos, moving);
      else n_pass++;
      mouse_ypos = 12'd534;
      step();
      mouse_left = 1'b1;
      step();
      frame();
      frame();
      frame();
      n_chk++;
      if (ypos !== 12'd535 || moving !== 1'b1)
         $display("FAIL hold_one_click y=%0d mv=%0b want 535 1",
                  ypos, moving);
      else n_pass++;
      mouse_left = 1'b0;
      step();
      n_chk++;
      if (ypos !== 12'd535 || moving !== 1'b1)
         $display("FAIL release_noop y=%0d mv=%0b want 535 1",
                  ypos, moving);
      else n_pass++;
      frame();
      frame();
      n_chk++;
      if (ypos !== 12'd536 || moving !== 1'b0)
         $display("FAIL hold_rest y=%0d mv=%0b want 536 0",
                  ypos, moving);
      else n_pass++;
      mouse_ypos = 12'd300;
      press();
      n_chk++;
      if (ypos !== 12'd300)
         $display("FAIL second_press y=%0d want 300", ypos);
      else n_pass++;
   endtask

   initial begin
      rst        = 1'b1;
      vblnk      = 1'b0;
      mouse_left = 1'b0;
      mouse_xpos = '0;
      mouse_ypos = '0;
      test_reset();
      test_follow();
      test_fall_bounce();
      test_click_tick();
      test_ripple();
      test_hold();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
